// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: opcodes, exception codes,
// FSM states, bus structs and small decode helpers.
package mem_stage_pkg;

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2B;

   localparam logic [5:0] EXC_ADEL = 6'b100100;
   localparam logic [5:0] EXC_ADES = 6'b100101;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef enum logic [1:0] {
      MEM_IDLE = 2'd0,
      MEM_ADDR = 2'd1,
      MEM_DATA = 2'd2,
      MEM_DONE = 2'd3
   } mem_state_t;

   typedef struct packed {
      logic        valid;
      logic        write;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [3:0]  strobe;
      logic [31:0] data;
   } dreq_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } dresp_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] val3;
      logic [31:0] valt;
      logic [5:0]  icode;
      logic [5:0]  acode;
      logic [5:0]  exc_code;
      logic [4:0]  dst;
      logic        in_ds;
   } pipe_t;

   localparam pipe_t PIPE_NOP = {32'h0, 32'h0, 32'h0, 6'h0, 6'h0, 6'h0, 5'h0, 1'b0};

   function automatic logic is_load(input logic [5:0] icode);
      case (icode)
         OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: is_load = 1'b1;
         default:                             is_load = 1'b0;
      endcase
   endfunction

   function automatic logic is_store(input logic [5:0] icode);
      case (icode)
         OP_SB, OP_SH, OP_SW: is_store = 1'b1;
         default:             is_store = 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] mem_size(input logic [5:0] icode);
      case (icode)
         OP_LH, OP_LHU, OP_SH: mem_size = SIZE_HALF;
         OP_LW, OP_SW:         mem_size = SIZE_WORD;
         default:              mem_size = SIZE_BYTE;
      endcase
   endfunction

   // Only meaningful for memory ops; byte accesses are never misaligned.
   function automatic logic is_misaligned(input logic [5:0] icode, input logic [1:0] addr_lo);
      case (mem_size(icode))
         SIZE_HALF: is_misaligned = addr_lo[0];
         SIZE_WORD: is_misaligned = |addr_lo;
         default:   is_misaligned = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Byte-lane handling: store strobe/data replication and load lane
// extraction with sign or zero extension.
module mem_align
   import mem_stage_pkg::*;
(
   input  logic [5:0]  icode,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] load_word,
   output logic [3:0]  strobe,
   output logic [31:0] wdata,
   output logic [31:0] load_val
);

   logic [31:0] shifted_s;

   // Bring the addressed lane down to bits [15:0] / [7:0].
   assign shifted_s = load_word >> {addr_lo, 3'b000};

   // Store lane replication and byte enables.
   always_comb begin
      strobe = 4'b0000;
      wdata  = store_data;
      case (icode)
         OP_SB: begin
            strobe = 4'b0001 << addr_lo;
            wdata  = {4{store_data[7:0]}};
         end
         OP_SH: begin
            strobe = 4'b0011 << addr_lo;
            wdata  = {2{store_data[15:0]}};
         end
         OP_SW: begin
            strobe = 4'b1111;
            wdata  = store_data;
         end
         default: begin
            strobe = 4'b0000;
            wdata  = store_data;
         end
      endcase
   end

   // Load lane extraction and extension.
   always_comb begin
      load_val = load_word;
      case (icode)
         OP_LB:   load_val = {{24{shifted_s[7]}}, shifted_s[7:0]};
         OP_LBU:  load_val = {24'h000000, shifted_s[7:0]};
         OP_LH:   load_val = {{16{shifted_s[15]}}, shifted_s[15:0]};
         OP_LHU:  load_val = {16'h0000, shifted_s[15:0]};
         default: load_val = load_word;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: pipeline register, split address/data bus FSM,
// alignment exceptions and writeback value selection.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        M_stall,
   input  logic        M_bubble,
   input  logic [31:0] e_pc,
   input  logic [31:0] e_val3,
   input  logic [31:0] e_valt,
   input  logic [5:0]  e_icode,
   input  logic [5:0]  e_acode,
   input  logic [5:0]  e_excCode,
   input  logic [4:0]  e_dst,
   input  logic        e_inDelaySlot,
   output logic        dreq_valid,
   output logic        dreq_write,
   output logic [1:0]  dreq_size,
   output logic [31:0] dreq_addr,
   output logic [3:0]  dreq_strobe,
   output logic [31:0] dreq_data,
   input  logic        dresp_addr_ok,
   input  logic        dresp_data_ok,
   input  logic [31:0] dresp_data,
   output logic [31:0] m_pc,
   output logic [31:0] m_val,
   output logic [4:0]  m_dst,
   output logic [5:0]  m_excCode,
   output logic [31:0] m_badvaddr,
   output logic        m_inDelaySlot,
   output logic        m_busy
);

   pipe_t       pipe_r;
   pipe_t       e_pipe_s;
   mem_state_t  state_r;
   mem_state_t  state_nxt_s;
   logic [31:0] rdata_r;
   dreq_t       dreq_s;
   dresp_t      dresp_s;
   logic        e_legal_s;
   logic        r_mem_s;
   logic        r_exc_in_s;
   logic        r_misal_s;
   logic        r_legal_s;
   logic        r_fault_s;
   logic        r_load_s;
   logic        r_store_s;
   logic        data_fire_s;
   logic [3:0]  strobe_s;
   logic [31:0] wdata_s;
   logic [31:0] load_val_s;
   logic        unused_acode_s;

   assign e_pipe_s = '{pc: e_pc, val3: e_val3, valt: e_valt, icode: e_icode,
                       acode: e_acode, exc_code: e_excCode, dst: e_dst,
                       in_ds: e_inDelaySlot};
   assign dresp_s  = '{addr_ok: dresp_addr_ok, data_ok: dresp_data_ok, data: dresp_data};

   // The function code has no role in this stage but is carried along.
   assign unused_acode_s = ^pipe_r.acode;

   // Legality of the op about to be captured decides whether the bus
   // request starts in the very next cycle.
   assign e_legal_s = is_load(e_icode) | is_store(e_icode) ? (~e_excCode[5] & ~is_misaligned(e_icode, e_val3[1:0])) : 1'b0;

   assign r_load_s   = is_load(pipe_r.icode);
   assign r_store_s  = is_store(pipe_r.icode);
   assign r_mem_s    = r_load_s | r_store_s;
   assign r_exc_in_s = pipe_r.exc_code[5];
   assign r_misal_s  = r_mem_s & ~r_exc_in_s & is_misaligned(pipe_r.icode, pipe_r.val3[1:0]);
   assign r_legal_s  = r_mem_s & ~r_exc_in_s & ~r_misal_s;
   assign r_fault_s  = r_exc_in_s | r_misal_s;

   // Pipeline register: stall holds and wins over bubble.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         pipe_r <= PIPE_NOP;
      end else if (M_stall) begin
         pipe_r <= pipe_r;
      end else if (M_bubble) begin
         pipe_r <= PIPE_NOP;
      end else begin
         pipe_r <= e_pipe_s;
      end
   end

   // Bus FSM state register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_r <= MEM_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Bus FSM next state; data_ok before addr_ok is ignored in ADDR.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         MEM_IDLE, MEM_DONE: begin
            if (M_stall) begin
               state_nxt_s = state_r;
            end else if (M_bubble) begin
               state_nxt_s = MEM_IDLE;
            end else if (e_legal_s) begin
               state_nxt_s = MEM_ADDR;
            end else begin
               state_nxt_s = MEM_IDLE;
            end
         end
         MEM_ADDR: begin
            if (dresp_s.addr_ok) begin
               if (dresp_s.data_ok) begin
                  state_nxt_s = MEM_DONE;
               end else begin
                  state_nxt_s = MEM_DATA;
               end
            end else begin
               state_nxt_s = MEM_ADDR;
            end
         end
         MEM_DATA: begin
            if (dresp_s.data_ok) begin
               state_nxt_s = MEM_DONE;
            end else begin
               state_nxt_s = MEM_DATA;
            end
         end
         default: state_nxt_s = MEM_IDLE;
      endcase
   end

   assign data_fire_s = ((state_r == MEM_ADDR) & dresp_s.addr_ok & dresp_s.data_ok)
                      | ((state_r == MEM_DATA) & dresp_s.data_ok);

   // Latch the returned word when the data phase completes.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rdata_r <= 32'h0000_0000;
      end else if (data_fire_s) begin
         rdata_r <= dresp_s.data;
      end else begin
         rdata_r <= rdata_r;
      end
   end

   mem_align u_align (
      .icode      (pipe_r.icode),
      .addr_lo    (pipe_r.val3[1:0]),
      .store_data (pipe_r.valt),
      .load_word  (rdata_r),
      .strobe     (strobe_s),
      .wdata      (wdata_s),
      .load_val   (load_val_s)
   );

   // Bus request fields come only from the pipeline register.
   always_comb begin
      dreq_s.valid  = (state_r == MEM_ADDR);
      dreq_s.write  = r_store_s;
      dreq_s.size   = mem_size(pipe_r.icode);
      dreq_s.addr   = pipe_r.val3;
      dreq_s.strobe = strobe_s;
      dreq_s.data   = wdata_s;
   end

   assign dreq_valid  = dreq_s.valid;
   assign dreq_write  = dreq_s.write;
   assign dreq_size   = dreq_s.size;
   assign dreq_addr   = dreq_s.addr;
   assign dreq_strobe = dreq_s.strobe;
   assign dreq_data   = dreq_s.data;

   // Writeback value, destination and exception reporting.
   always_comb begin
      m_val      = pipe_r.val3;
      m_dst      = pipe_r.dst;
      m_excCode  = pipe_r.exc_code;
      m_badvaddr = 32'h0000_0000;
      if (r_fault_s || r_store_s) begin
         m_val = 32'h0000_0000;
         m_dst = 5'd0;
      end else if (r_load_s) begin
         m_val = (state_r == MEM_DONE) ? load_val_s : 32'h0000_0000;
      end else begin
         m_val = pipe_r.val3;
      end
      if (r_misal_s) begin
         m_excCode  = r_load_s ? EXC_ADEL : EXC_ADES;
         m_badvaddr = pipe_r.val3;
      end else begin
         m_excCode  = pipe_r.exc_code;
         m_badvaddr = 32'h0000_0000;
      end
   end

   assign m_pc          = pipe_r.pc;
   assign m_inDelaySlot = pipe_r.in_ds;
   assign m_busy        = r_legal_s & (state_r != MEM_DONE);

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a load-result scoreboard.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk = 1'b0;
   logic        resetn, M_stall, M_bubble;
   logic [31:0] e_pc, e_val3, e_valt;
   logic [5:0]  e_icode, e_acode, e_excCode;
   logic [4:0]  e_dst;
   logic        e_inDelaySlot;
   logic        dreq_valid, dreq_write;
   logic [1:0]  dreq_size;
   logic [31:0] dreq_addr, dreq_data;
   logic [3:0]  dreq_strobe;
   logic        dresp_addr_ok, dresp_data_ok;
   logic [31:0] dresp_data;
   logic [31:0] m_pc, m_val, m_badvaddr;
   logic [4:0]  m_dst;
   logic [5:0]  m_excCode;
   logic        m_inDelaySlot, m_busy;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];

   mem_stage dut (
      .clk(clk), .resetn(resetn), .M_stall(M_stall), .M_bubble(M_bubble),
      .e_pc(e_pc), .e_val3(e_val3), .e_valt(e_valt), .e_icode(e_icode),
      .e_acode(e_acode), .e_excCode(e_excCode), .e_dst(e_dst),
      .e_inDelaySlot(e_inDelaySlot),
      .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_size(dreq_size),
      .dreq_addr(dreq_addr), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
      .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
      .dresp_data(dresp_data),
      .m_pc(m_pc), .m_val(m_val), .m_dst(m_dst), .m_excCode(m_excCode),
      .m_badvaddr(m_badvaddr), .m_inDelaySlot(m_inDelaySlot), .m_busy(m_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_pop(input string tag, input logic [31:0] obs);
      logic [31:0] exp_v;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $error("FAIL %s: observed %h expected <scoreboard empty>", tag, obs);
      end else begin
         exp_v = exp_q.pop_front();
         chk(tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_nop();
      e_pc = 32'h0; e_val3 = 32'h0; e_valt = 32'h0; e_icode = 6'h0;
      e_acode = 6'h0; e_excCode = 6'h0; e_dst = 5'd0; e_inDelaySlot = 1'b0;
   endtask

   // Capture one op, then hold the stage as the hazard unit would.
   task automatic issue(input logic [5:0] icode, input logic [31:0] addr,
                        input logic [31:0] rt, input logic [4:0] dst,
                        input logic [31:0] pc, input logic [5:0] exc);
      e_icode = icode; e_val3 = addr; e_valt = rt; e_dst = dst; e_pc = pc;
      e_excCode = exc; e_acode = 6'h11; e_inDelaySlot = 1'b0;
      M_stall = 1'b0; M_bubble = 1'b0;
      step();
      M_stall = 1'b1;
      drive_nop();
   endtask

   // Slave answers address and data in the same cycle.
   task automatic bus_one(input logic [31:0] data);
      dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = data;
      step();
      dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 32'h0;
   endtask

   initial begin
      int busy_cnt;
      int valid_cnt;
      logic stable;

      resetn = 1'b0; M_stall = 1'b0; M_bubble = 1'b0; drive_nop();
      dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 32'h0;
      step(); step();
      chk("rst_m_pc", m_pc, 32'h0);
      chk("rst_m_val", m_val, 32'h0);
      chk("rst_m_dst", {27'h0, m_dst}, 32'h0);
      chk("rst_m_exc", {26'h0, m_excCode}, 32'h0);
      chk("rst_dreq_valid", {31'h0, dreq_valid}, 32'h0);
      chk("rst_m_busy", {31'h0, m_busy}, 32'h0);
      resetn = 1'b1;

      // LW, single-cycle slave
      issue(OP_LW, 32'h8000_0010, 32'h0, 5'd5, 32'h0000_0100, 6'h0);
      exp_q.push_back(32'hDEAD_BEEF);
      chk("lw_valid", {31'h0, dreq_valid}, 32'h1);
      chk("lw_busy", {31'h0, m_busy}, 32'h1);
      chk("lw_addr", dreq_addr, 32'h8000_0010);
      chk("lw_size_wr", {29'h0, dreq_write, dreq_size}, {29'h0, 3'b010});
      chk("lw_strobe", {28'h0, dreq_strobe}, 32'h0);
      bus_one(32'hDEAD_BEEF);
      chk("lw_valid_drop", {31'h0, dreq_valid}, 32'h0);
      chk("lw_busy_drop", {31'h0, m_busy}, 32'h0);
      chk_pop("lw_val", m_val);
      chk("lw_dst", {27'h0, m_dst}, 32'd5);
      chk("lw_pc", m_pc, 32'h0000_0100);

      // LB then LBU on the top byte lane
      issue(OP_LB, 32'h0000_0013, 32'h0, 5'd4, 32'h0000_0104, 6'h0);
      exp_q.push_back(32'hFFFF_FF80);
      chk("lb_size", {30'h0, dreq_size}, 32'h0);
      bus_one(32'h80FF_0000);
      chk_pop("lb_val", m_val);
      issue(OP_LBU, 32'h0000_0013, 32'h0, 5'd4, 32'h0000_0108, 6'h0);
      exp_q.push_back(32'h0000_0080);
      chk("lbu_valid", {31'h0, dreq_valid}, 32'h1);
      bus_one(32'h80FF_0000);
      chk_pop("lbu_val", m_val);

      // SH on upper half
      issue(OP_SH, 32'h0000_0002, 32'h1234_ABCD, 5'd7, 32'h0000_010C, 6'h0);
      chk("sh_strobe", {28'h0, dreq_strobe}, 32'hC);
      chk("sh_data", dreq_data, 32'hABCD_ABCD);
      chk("sh_size_wr", {29'h0, dreq_write, dreq_size}, {29'h0, 3'b101});
      bus_one(32'h0);
      chk("sh_dst", {27'h0, m_dst}, 32'h0);
      chk("sh_val", m_val, 32'h0);

      // SB lane 1
      issue(OP_SB, 32'h0000_0021, 32'h0000_005A, 5'd2, 32'h0000_0110, 6'h0);
      chk("sb_strobe", {28'h0, dreq_strobe}, 32'h2);
      chk("sb_data", dreq_data, 32'h5A5A_5A5A);
      bus_one(32'h0);

      // Misaligned halfword load and word store
      issue(OP_LH, 32'h0000_0001, 32'h0, 5'd6, 32'h0000_0114, 6'h0);
      chk("lh_mis_valid", {31'h0, dreq_valid}, 32'h0);
      chk("lh_mis_busy", {31'h0, m_busy}, 32'h0);
      chk("lh_mis_exc", {26'h0, m_excCode}, {26'h0, 6'b100100});
      chk("lh_mis_bad", m_badvaddr, 32'h0000_0001);
      chk("lh_mis_dst", {27'h0, m_dst}, 32'h0);
      step();
      chk("lh_mis_no_req", {31'h0, dreq_valid}, 32'h0);
      issue(OP_SW, 32'h0000_0046, 32'h1, 5'd6, 32'h0000_0118, 6'h0);
      chk("sw_mis_exc", {26'h0, m_excCode}, {26'h0, 6'b100101});
      chk("sw_mis_bad", m_badvaddr, 32'h0000_0046);

      // Incoming exception on an aligned load
      issue(OP_LW, 32'h0000_0040, 32'h0, 5'd9, 32'h0000_011C, 6'b101010);
      chk("exc_in_code", {26'h0, m_excCode}, {26'h0, 6'b101010});
      chk("exc_in_bad", m_badvaddr, 32'h0);
      chk("exc_in_valid", {31'h0, dreq_valid}, 32'h0);
      chk("exc_in_busy", {31'h0, m_busy}, 32'h0);

      // Non-memory op; then stall beats bubble; then bubble clears
      issue(6'h08, 32'h1111_2222, 32'h0, 5'd3, 32'h0000_0120, 6'h0);
      chk("alu_val", m_val, 32'h1111_2222);
      chk("alu_dst", {27'h0, m_dst}, 32'd3);
      chk("alu_busy", {31'h0, m_busy}, 32'h0);
      M_stall = 1'b1; M_bubble = 1'b1;
      step();
      chk("stall_prio_dst", {27'h0, m_dst}, 32'd3);
      M_stall = 1'b0;
      step();
      chk("bubble_dst", {27'h0, m_dst}, 32'h0);
      chk("bubble_pc", m_pc, 32'h0);
      M_bubble = 1'b0;

      // LHU with addr_ok after 3 idle cycles and data_ok 2 later; an early
      // data_ok carrying garbage must be ignored
      issue(OP_LHU, 32'h0000_0106, 32'h0, 5'd8, 32'h0000_0124, 6'h0);
      exp_q.push_back(32'h0000_BEEF);
      busy_cnt = 0; valid_cnt = 0; stable = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (!m_busy) break;
         busy_cnt++;
         if (dreq_valid) begin
            valid_cnt++;
            if (dreq_addr !== 32'h0000_0106 || dreq_size !== 2'd1 ||
                dreq_write !== 1'b0 || dreq_strobe !== 4'h0) stable = 1'b0;
         end
         dresp_addr_ok = (i == 3);
         dresp_data_ok = (i == 1) || (i == 5);
         dresp_data    = (i == 5) ? 32'hBEEF_1234 : 32'hFFFF_FFFF;
         step();
      end
      dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 32'h1357_9BDF;
      chk("dly_busy_cycles", busy_cnt, 32'd6);
      chk("dly_valid_cycles", valid_cnt, 32'd4);
      chk("dly_stable", {31'h0, stable}, 32'h1);
      chk_pop("dly_val", m_val);
      step(); step();
      chk("done_hold_val", m_val, 32'h0000_BEEF);
      chk("done_hold_busy", {31'h0, m_busy}, 32'h0);

      // Reset in the middle of the data phase
      issue(OP_LW, 32'h0000_0020, 32'h0, 5'd10, 32'h0000_0128, 6'h0);
      dresp_addr_ok = 1'b1;
      step();
      dresp_addr_ok = 1'b0;
      chk("mid_data_valid", {31'h0, dreq_valid}, 32'h0);
      chk("mid_data_busy", {31'h0, m_busy}, 32'h1);
      resetn = 1'b0;
      step();
      chk("mid_rst_valid", {31'h0, dreq_valid}, 32'h0);
      chk("mid_rst_busy", {31'h0, m_busy}, 32'h0);
      chk("mid_rst_pc", m_pc, 32'h0);
      chk("mid_rst_val", m_val, 32'h0);
      chk("mid_rst_dst", {27'h0, m_dst}, 32'h0);
      chk("mid_rst_exc_ds", {25'h0, m_excCode, m_inDelaySlot}, 32'h0);
      resetn = 1'b1;
      issue(OP_LW, 32'h0000_0024, 32'h0, 5'd11, 32'h0000_012C, 6'h0);
      exp_q.push_back(32'h0BAD_F00D);
      chk("post_rst_valid", {31'h0, dreq_valid}, 32'h1);
      bus_one(32'h0BAD_F00D);
      chk_pop("post_rst_val", m_val);

      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
